// File: rtl/mmio_ctrl_regs_if.sv
// Host MMIO channel: the host issues writes and read requests, the register block returns read data.
interface mmio_if;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [63:0] rd_data;

    modport host (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
    modport user (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/mmio_ctrl_regs.sv
// Control/status register block for the accelerator: start address, arguments, go/done
// handshake, run-cycle counter, soft-reset pulse and unhalt control behind a host MMIO channel.
module mmio_ctrl_regs #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned NUM_ARGS     = 4,
    parameter logic [15:0] BASE_ADDR    = 16'h0050,
    parameter int unsigned RESET_CYCLES = 8,
    parameter int unsigned CNT_WIDTH    = 48
) (
    input  logic                                clk,
    input  logic                                rst,
    mmio_if.user                                mmio,
    output logic [ADDR_WIDTH-1:0]               start_addr,
    output logic [NUM_ARGS-1:0][ADDR_WIDTH-1:0] args,
    output logic                                go,
    output logic                                soft_reset,
    output logic                                unhalt,
    output logic                                busy,
    input  logic                                done
);
    localparam logic [14:0] LP_NUM_REGS     = 15'(5 + NUM_ARGS);
    localparam logic [7:0]  LP_RESET_CYCLES = 8'(RESET_CYCLES);

    logic [63:0]          r_scratch;
    logic                 r_doneSticky;
    logic                 r_doneQ;
    logic [CNT_WIDTH-1:0] r_cycles;
    logic [7:0]           r_srCount;

    logic [15:0] w_wrOff;
    logic [15:0] w_rdOff;
    logic [14:0] w_wrIdx;
    logic [14:0] w_rdIdx;
    logic        w_wrHit;
    logic        w_rdHit;
    logic        w_ctrlWr;
    logic        w_statusW1c;
    logic        w_srStart;
    logic        w_block;
    logic        w_goWr;
    logic        w_doneRise;
    logic [7:0]  w_srNext;
    logic [63:0] w_rdValue;

    // Registers sit at even word offsets from the base; subtraction wraps addresses below the base out of range.
    assign w_wrOff     = mmio.wr_addr - BASE_ADDR;
    assign w_rdOff     = mmio.rd_addr - BASE_ADDR;
    assign w_wrIdx     = w_wrOff[15:1];
    assign w_rdIdx     = w_rdOff[15:1];
    assign w_wrHit     = mmio.wr_en && !w_wrOff[0] && (w_wrIdx < LP_NUM_REGS);
    assign w_rdHit     = !w_rdOff[0] && (w_rdIdx < LP_NUM_REGS);
    assign w_ctrlWr    = w_wrHit && (w_wrIdx == 15'd0);
    assign w_statusW1c = w_wrHit && (w_wrIdx == 15'd2) && mmio.wr_data[0];
    assign w_srStart   = w_ctrlWr && mmio.wr_data[1];
    assign w_block     = soft_reset || w_srStart;
    assign w_goWr      = w_ctrlWr && mmio.wr_data[0] && !w_block;
    assign w_doneRise  = done && !r_doneQ;
    assign w_srNext    = w_srStart ? LP_RESET_CYCLES :
                         (r_srCount != 8'd0) ? (r_srCount - 8'd1) : 8'd0;

    always_comb begin
        w_rdValue = 64'd0;
        if (w_rdHit) begin
            case (w_rdIdx)
                15'd1:   w_rdValue = 64'(start_addr);
                15'd2:   w_rdValue = {59'd0, done, soft_reset, unhalt, busy, r_doneSticky};
                15'd3:   w_rdValue = 64'(r_cycles);
                15'd4:   w_rdValue = r_scratch;
                default: begin
                    for (int i = 0; i < int'(NUM_ARGS); i++) begin
                        if (w_rdIdx == 15'(5 + i)) w_rdValue = 64'(args[i]);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mmio.rd_data <= 64'd0;
        end else if (mmio.rd_en) begin
            mmio.rd_data <= w_rdValue;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_addr <= '0;
            args       <= '0;
            r_scratch  <= 64'd0;
        end else if (w_wrHit) begin
            if (w_wrIdx == 15'd1) start_addr <= mmio.wr_data[ADDR_WIDTH-1:0];
            if (w_wrIdx == 15'd4) r_scratch <= mmio.wr_data;
            for (int i = 0; i < int'(NUM_ARGS); i++) begin
                if (w_wrIdx == 15'(5 + i)) args[i] <= mmio.wr_data[ADDR_WIDTH-1:0];
            end
        end
    end

    // Priority: soft reset over go, go over done rise, done rise over the sticky-flag clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_doneQ      <= 1'b0;
            r_srCount    <= 8'd0;
            soft_reset   <= 1'b0;
            go           <= 1'b0;
            busy         <= 1'b0;
            r_doneSticky <= 1'b0;
            r_cycles     <= '0;
            unhalt       <= 1'b0;
        end else begin
            r_doneQ    <= done;
            r_srCount  <= w_srNext;
            soft_reset <= (w_srNext != 8'd0);
            go         <= w_goWr;
            if (w_block) begin
                busy         <= 1'b0;
                r_doneSticky <= 1'b0;
                r_cycles     <= '0;
                unhalt       <= 1'b0;
            end else begin
                if (w_goWr) begin
                    busy         <= 1'b1;
                    r_doneSticky <= 1'b0;
                    r_cycles     <= '0;
                end else begin
                    if (busy && (r_cycles != '1)) r_cycles <= r_cycles + CNT_WIDTH'(1);
                    if (w_doneRise) begin
                        busy         <= 1'b0;
                        r_doneSticky <= 1'b1;
                    end else if (w_statusW1c) begin
                        r_doneSticky <= 1'b0;
                    end
                end
                if (w_ctrlWr && mmio.wr_data[3]) begin
                    unhalt <= 1'b0;
                end else if (w_ctrlWr && mmio.wr_data[2]) begin
                    unhalt <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mmio_ctrl_regs.sv
// Bench for mmio_ctrl_regs: directed MMIO traffic, a register-map reference model compared every
// cycle, and hand-computed expectations for the go/done, race, soft-reset and saturation cases.
module tb_mmio_ctrl_regs;
    localparam int          AW    = 48;
    localparam int          NA    = 4;
    localparam logic [15:0] BASE  = 16'h0050;
    localparam int          RC    = 8;
    localparam int          CW    = 4;
    localparam int          NREGS = 5 + NA;
    localparam logic [63:0] AMASK = (64'd1 << AW) - 64'd1;
    localparam logic [63:0] CMAX  = (64'd1 << CW) - 64'd1;

    localparam logic [15:0] A_CTRL    = BASE;
    localparam logic [15:0] A_START   = BASE + 16'd2;
    localparam logic [15:0] A_STATUS  = BASE + 16'd4;
    localparam logic [15:0] A_CYCLES  = BASE + 16'd6;
    localparam logic [15:0] A_SCRATCH = BASE + 16'd8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 done = 1'b0;
    logic [AW-1:0]        startAddr;
    logic [NA-1:0][AW-1:0] args;
    logic                 go, softReset, unhalt, busy;

    mmio_if mmio();

    mmio_ctrl_regs #(
        .ADDR_WIDTH(AW), .NUM_ARGS(NA), .BASE_ADDR(BASE), .RESET_CYCLES(RC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .mmio(mmio), .start_addr(startAddr), .args(args),
        .go(go), .soft_reset(softReset), .unhalt(unhalt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;
    logic checkOn = 1'b0;

    logic [63:0] regFile [NREGS];
    logic        mGo, mUnhalt, mBusy, mSticky, mDonePrev;
    logic [63:0] mCycles, mRd;
    int          cyc = 0;
    int          srLast = -1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int mapIndex(input logic [15:0] addr);
        int off;
        off = int'(addr) - int'(BASE);
        if (off < 0 || (off % 2) != 0 || (off / 2) >= NREGS) return -1;
        return off / 2;
    endfunction

    function automatic logic [63:0] readModel(input int idx, input logic dn, input logic srOn);
        if (idx == 1 || idx >= 4) return regFile[idx];
        if (idx == 2) return {59'd0, dn, srOn, mUnhalt, mBusy, mSticky};
        if (idx == 3) return mCycles;
        return 64'd0;
    endfunction

    // Reference model: soft reset is a window of absolute cycle numbers, the counter a clamped integer.
    always @(posedge clk or posedge rst) begin
        int         rIdx, wIdx;
        logic       srOn, rise, w1c;
        logic [3:0] ctrl;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regFile[i] = 64'd0;
            mGo = 0; mUnhalt = 0; mBusy = 0; mSticky = 0; mDonePrev = 0;
            mCycles = 64'd0; mRd = 64'd0; srLast = -1;
        end else begin
            srOn = (cyc <= srLast);
            cyc++;
            rIdx = mapIndex(mmio.rd_addr);
            wIdx = mapIndex(mmio.wr_addr);
            if (mmio.rd_en) mRd = readModel(rIdx, done, srOn);
            rise = done && !mDonePrev;
            mDonePrev = done;
            ctrl = (mmio.wr_en && wIdx == 0) ? mmio.wr_data[3:0] : 4'h0;
            w1c = mmio.wr_en && wIdx == 2 && mmio.wr_data[0];
            if (mmio.wr_en && (wIdx == 1 || wIdx >= 4))
                regFile[wIdx] = mmio.wr_data & ((wIdx == 4) ? 64'hFFFF_FFFF_FFFF_FFFF : AMASK);
            if (ctrl[1]) srLast = cyc + RC - 1;
            if (srOn || ctrl[1]) begin
                mGo = 0; mBusy = 0; mSticky = 0; mCycles = 64'd0; mUnhalt = 0;
            end else begin
                mGo = ctrl[0];
                if (ctrl[0]) begin
                    mBusy = 1; mSticky = 0; mCycles = 64'd0;
                end else begin
                    if (mBusy && mCycles < CMAX) mCycles = mCycles + 64'd1;
                    if (rise) begin
                        mBusy = 0; mSticky = 1;
                    end else if (w1c) begin
                        mSticky = 0;
                    end
                end
                if (ctrl[3]) mUnhalt = 0;
                else if (ctrl[2]) mUnhalt = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && checkOn) begin
                checkOutput("model go", 64'(go), 64'(mGo));
                checkOutput("model soft_reset", 64'(softReset), 64'(cyc <= srLast));
                checkOutput("model unhalt", 64'(unhalt), 64'(mUnhalt));
                checkOutput("model busy", 64'(busy), 64'(mBusy));
                checkOutput("model start_addr", 64'(startAddr), regFile[1]);
                for (int i = 0; i < NA; i++)
                    checkOutput($sformatf("model args[%0d]", i), 64'(args[i]), regFile[5 + i]);
                checkOutput("model rd_data", mmio.rd_data, mRd);
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [15:0] wa, input logic [63:0] wd,
                                 input logic re, input logic [15:0] ra);
        mmio.wr_en = we; mmio.wr_addr = wa; mmio.wr_data = wd;
        mmio.rd_en = re; mmio.rd_addr = ra;
        @(negedge clk);
        mmio.wr_en = 1'b0; mmio.rd_en = 1'b0;
    endtask

    task automatic writeReg(input logic [15:0] a, input logic [63:0] d);
        applyStimulus(1'b1, a, d, 1'b0, 16'd0);
    endtask

    task automatic readReg(input logic [15:0] a);
        applyStimulus(1'b0, 16'd0, 64'd0, 1'b1, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'd0, 64'd0, 1'b0, 16'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int srCount, goCount;
        mmio.wr_en = 0; mmio.wr_addr = 0; mmio.wr_data = 0; mmio.rd_en = 0; mmio.rd_addr = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset go", 64'(go), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset soft_reset", 64'(softReset), 64'd0);
        checkOutput("reset rd_data", mmio.rd_data, 64'd0);
        rst = 1'b0;
        checkOn = 1'b1;

        for (int i = 0; i < NREGS; i++) begin
            readReg(BASE + 16'(2 * i));
            checkOutput($sformatf("reset read reg%0d", i), mmio.rd_data, 64'd0);
        end

        writeReg(A_SCRATCH, 64'hDEAD_BEEF_0123_4567);
        writeReg(A_START, 64'hFFFF_1234_5678_9ABC);
        writeReg(16'h0060, 64'd5);
        writeReg(16'h0053, 64'hAAAA_AAAA_AAAA_AAAA);
        readReg(A_SCRATCH);
        checkOutput("scratch readback", mmio.rd_data, 64'hDEAD_BEEF_0123_4567);
        readReg(A_START);
        checkOutput("start_addr readback", mmio.rd_data, 64'h0000_1234_5678_9ABC);
        readReg(16'h0060);
        checkOutput("arg3 readback", mmio.rd_data, 64'd5);
        readReg(16'h0051);
        checkOutput("odd address read", mmio.rd_data, 64'd0);
        readReg(16'h0060);
        readReg(16'h0070);
        checkOutput("unmapped read", mmio.rd_data, 64'd0);

        writeReg(A_CTRL, 64'd1);
        checkOutput("go pulse high", 64'(go), 64'd1);
        checkOutput("busy after go", 64'(busy), 64'd1);
        idle(1);
        checkOutput("go pulse single cycle", 64'(go), 64'd0);
        idle(8);
        done = 1'b1;
        idle(1);
        checkOutput("busy after done", 64'(busy), 64'd0);
        readReg(A_CYCLES);
        checkOutput("cycles after run", mmio.rd_data, 64'd10);
        readReg(A_STATUS);
        checkOutput("status while done high", mmio.rd_data, 64'h11);
        done = 1'b0;
        writeReg(A_STATUS, 64'd1);
        readReg(A_STATUS);
        checkOutput("status after w1c", mmio.rd_data, 64'h0);

        done = 1'b1;
        writeReg(A_CTRL, 64'd1);
        checkOutput("race go+done busy", 64'(busy), 64'd1);
        readReg(A_STATUS);
        checkOutput("race go+done status", mmio.rd_data, 64'h12);
        done = 1'b0;
        idle(1);
        done = 1'b1;
        writeReg(A_STATUS, 64'd1);
        readReg(A_STATUS);
        checkOutput("race w1c+done status", mmio.rd_data, 64'h11);

        done = 1'b0;
        writeReg(A_CTRL, 64'd1);
        done = 1'b1;
        idle(4);
        readReg(A_STATUS);
        checkOutput("done held status", mmio.rd_data, 64'h11);
        writeReg(A_STATUS, 64'd1);
        readReg(A_STATUS);
        checkOutput("w1c while done held", mmio.rd_data, 64'h10);
        done = 1'b0;
        readReg(A_STATUS);
        checkOutput("status after done low", mmio.rd_data, 64'h0);

        writeReg(A_CTRL, 64'd4);
        writeReg(A_CTRL, 64'd1);
        writeReg(A_CTRL, 64'd2);
        checkOutput("soft reset clears busy", 64'(busy), 64'd0);
        checkOutput("soft reset clears unhalt", 64'(unhalt), 64'd0);
        srCount = softReset ? 1 : 0;
        goCount = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) writeReg(A_CTRL, 64'd1);
            else idle(1);
            if (softReset) srCount++;
            if (go) goCount++;
        end
        checkOutput("soft reset length", 64'(srCount), 64'd8);
        checkOutput("go during soft reset", 64'(goCount), 64'd0);

        writeReg(A_CTRL, 64'd2);
        srCount = softReset ? 1 : 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 4) writeReg(A_CTRL, 64'd2);
            else idle(1);
            if (softReset) srCount++;
        end
        checkOutput("soft reset retrigger length", 64'(srCount), 64'd13);
        readReg(A_START);
        checkOutput("start_addr kept over soft reset", mmio.rd_data, 64'h0000_1234_5678_9ABC);

        writeReg(A_CTRL, 64'd4);
        checkOutput("unhalt set", 64'(unhalt), 64'd1);
        writeReg(A_CTRL, 64'd8);
        checkOutput("unhalt clear", 64'(unhalt), 64'd0);
        writeReg(A_CTRL, 64'd4);
        writeReg(A_CTRL, 64'd12);
        checkOutput("unhalt set+clear", 64'(unhalt), 64'd0);

        writeReg(A_CTRL, 64'd1);
        idle(20);
        readReg(A_CYCLES);
        checkOutput("cycles saturate", mmio.rd_data, 64'd15);
        checkOutput("busy before async reset", 64'(busy), 64'd1);

        #2 rst = 1'b1;
        #1;
        checkOutput("async reset busy", 64'(busy), 64'd0);
        checkOutput("async reset rd_data", mmio.rd_data, 64'd0);
        checkOutput("async reset start_addr", 64'(startAddr), 64'd0);
        checkOutput("async reset arg3", 64'(args[3]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        readReg(A_SCRATCH);
        checkOutput("scratch after reset", mmio.rd_data, 64'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
